regfile_scoreboard_bypass: RTL

Parametrised successor to the 8×8 register file for the next RISC core generation. Generic width, depth and read-port count, optional hard-wired zero register, and write-to-read bypass. Adds a per-register busy scoreboard (set on issue, cleared on write-back) so decode can detect RAW hazards. Sits between decode (read and issue side) and write-back (write side).

---
 rtl/regfile_scoreboard_bypass_pkg.sv | 20 ++
 rtl/regfile_scoreboard_bypass_if.sv | 32 +++
 rtl/regfile_scoreboard_bypass_scoreboard.sv | 72 +++++++
 rtl/regfile_scoreboard_bypass.sv | 67 ++++++
 4 files changed

// File: rtl/regfile_scoreboard_bypass_pkg.sv
// Shared constants, helpers and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard_bypass_if.sv
// Decode/write-back side bundle of the scoreboarded register file.
interface regfile_scoreboard_bypass_if #(
  parameter int DATA_W   = regfile_pkg::DEF_DATA_W,
  parameter int NUM_REGS = regfile_pkg::DEF_NUM_REGS,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = regfile_pkg::addr_w(NUM_REGS);
  localparam int CNT_W  = regfile_pkg::cnt_w(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;
  logic [CNT_W-1:0]         busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output issue_en, issue_addr, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  issue_en, issue_addr, flush,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard_bypass_scoreboard.sv
// Busy scoreboard: issue sets, write-back clears, flush wipes;
// keeps an incremental busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  bit ZERO_REG = 1'b1,
  localparam int ADDR_W   = addr_w(NUM_REGS),
  localparam int CNT_W    = cnt_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        byp_hit,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [CNT_W-1:0]         busy_count
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] LIVE = ZERO_REG ? ~ONE : '1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                set_new, clr_old;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_en && !flush) set_vec = (ONE << issue_addr) & LIVE;
    if (wr_en) clr_vec = ONE << wr_addr;
    // a same-register issue outranks its own write-back
    set_new = |(set_vec & ~busy_q);
    clr_old = |(clr_vec & busy_q & ~set_vec);
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      busy_d = (busy_q & ~clr_vec) | set_vec;
      cnt_d  = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    assign rd_busy[i] =
      busy_q[rd_addr[i*ADDR_W +: ADDR_W]] & ~byp_hit[i];
  end

  assign busy_count = cnt_q;

  a_cnt_matches : assert property (
    @(posedge clk) disable iff (rst)
    cnt_q == CNT_W'($countones(busy_q))
  );

endmodule

// File: rtl/regfile_scoreboard_bypass.sv
// Parametrised register file with write bypass and a busy scoreboard
// for RAW hazard detection at decode.
module regfile_scoreboard_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_bypass_if.slave bus
);

  localparam int ADDR_W = addr_w(NUM_REGS);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NUM_RD-1:0]               byp_hit;
  logic                            wr_ok;

  assign wr_ok = bus.wr_en && !(ZERO_REG && bus.wr_addr == ZA);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zr;
    assign a  = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign zr = ZERO_REG && a == ZA;
    assign byp_hit[i] =
      BYPASS && bus.wr_en && bus.wr_addr == a && !zr;
    assign bus.rd_data[i*DATA_W +: DATA_W] =
      zr         ? '0 :
      byp_hit[i] ? bus.wr_data :
                   mem_q[a];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (bus.rd_addr),
    .byp_hit    (byp_hit),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .flush      (bus.flush),
    .rd_busy    (bus.rd_busy),
    .busy_count (bus.busy_count)
  );

endmodule
